// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: request/control codes, drain states and width helper for the hazard controller.
// The REQ_*/CTL_* macros extend the global macro set.
`ifndef PIPE_HAZARD_CTRL_CODES
`define PIPE_HAZARD_CTRL_CODES
`define REQ_NONE 2'b00
`define REQ_STALL 2'b01
`define REQ_FLUSH 2'b10
`define CTL_CONTINUE 2'b00
`define CTL_STALL 2'b01
`define CTL_BUBBLE 2'b10
`endif
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    REQ_NONE  = `REQ_NONE,
    REQ_STALL = `REQ_STALL,
    REQ_FLUSH = `REQ_FLUSH,
    REQ_RSVD  = 2'b11
  } req_e;
  typedef enum logic [1:0] {
    CTL_CONTINUE = `CTL_CONTINUE,
    CTL_STALL    = `CTL_STALL,
    CTL_BUBBLE   = `CTL_BUBBLE,
    CTL_RSVD     = 2'b11
  } ctl_e;
  typedef enum logic {RUN, DRAIN} state_e;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: request/control bundle between the pipeline stages and the hazard controller.
interface pipe_hazard_ctrl_if import pipe_hazard_ctrl_pkg::*; #(
  parameter int NSTAGE = 4,
  parameter int CNT_W  = 32
);
  localparam int SW = clog2_min1(NSTAGE);
  logic                rdy_in;
  logic [2*NSTAGE-1:0] req_i;
  logic [2*NSTAGE-1:0] ctl_o;
  logic                flush_o;
  logic [SW-1:0]       flush_stage_o;
  logic [CNT_W-1:0]    stall_cnt_o;
  logic [CNT_W-1:0]    flush_cnt_o;
  logic                wdog_o;
  modport master (
    output rdy_in, req_i,
    input  ctl_o, flush_o, flush_stage_o, stall_cnt_o, flush_cnt_o, wdog_o
  );
  modport slave (
    input  rdy_in, req_i,
    output ctl_o, flush_o, flush_stage_o, stall_cnt_o, flush_cnt_o, wdog_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  assign q_o = cnt_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for an NSTAGE in-order pipeline with redirect draining.
// Define PIPE_HAZARD_WDOG_EN to add the consecutive-stall watchdog; flush_o reports the flush accepted on the previous edge.
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int NSTAGE       = 4,
  parameter int REDIRECT_LAT = 0,
  parameter int CNT_W        = 32,
  parameter int WDOG_LIMIT   = 1024
) (
  input logic               clk_in,
  input logic               rst_in,
  pipe_hazard_ctrl_if.slave ifc
);
  localparam int SW = clog2_min1(NSTAGE);
  localparam int DW = clog2_min1(REDIRECT_LAT + 1);
  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [SW-1:0] fstage_q, s_idx, f_idx;
  logic          flush_q, stall_any, flush_any, p2, p3, stall_cyc, acc_flush;
  always_comb begin
    stall_any = 1'b0;
    flush_any = 1'b0;
    s_idx = '0;
    f_idx = '0;
    for (int s = 1; s < NSTAGE; s++) begin
      if (ifc.req_i[2*s +: 2] == REQ_STALL) begin
        stall_any = 1'b1;
        s_idx = SW'(s);
      end
      if (ifc.req_i[2*s +: 2] == REQ_FLUSH) begin
        flush_any = 1'b1;
        f_idx = SW'(s);
      end
    end
  end
  // Highest stage wins: a stall above the flusher blocks it, a flush above the staller squashes it.
  assign p2 = stall_any && (!flush_any || f_idx < s_idx);
  assign p3 = flush_any && (!stall_any || s_idx < f_idx);
  assign stall_cyc = ifc.rdy_in && p2;
  assign acc_flush = ifc.rdy_in && p3;
  always_comb begin
    ifc.ctl_o = '0;
    for (int k = 0; k < NSTAGE; k++)
      ifc.ctl_o[2*k +: 2] = (rst_in || !ifc.rdy_in) ? CTL_STALL
        : p2 ? (k <= int'(s_idx) ? CTL_STALL : k == int'(s_idx) + 1 ? CTL_BUBBLE : CTL_CONTINUE)
        : ((k == 1 && state_q == DRAIN) || (p3 && k >= 2 && k <= int'(f_idx))) ? CTL_BUBBLE
        : CTL_CONTINUE;
  end
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (acc_flush && REDIRECT_LAT > 0) begin
      state_d = DRAIN;
      drain_d = DW'(REDIRECT_LAT);
    end else if (state_q == DRAIN && ifc.rdy_in && !p2) begin
      drain_d = drain_q - DW'(1);
      state_d = drain_q == DW'(1) ? RUN : DRAIN;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q  <= RUN;
      drain_q  <= '0;
      flush_q  <= 1'b0;
      fstage_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      flush_q  <= acc_flush;
      fstage_q <= acc_flush ? f_idx : fstage_q;
    end
  assign ifc.flush_o = flush_q;
  assign ifc.flush_stage_o = fstage_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_in, .rst_in, .en_i(stall_cyc), .clr_i(1'b0), .q_o(ifc.stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_in, .rst_in, .en_i(acc_flush), .clr_i(1'b0), .q_o(ifc.flush_cnt_o)
  );
`ifdef PIPE_HAZARD_WDOG_EN
  localparam int WW = clog2_min1(WDOG_LIMIT + 1);
  logic [WW-1:0] run_cnt;
  logic          wdog_q;
  sat_counter #(.W(WW)) u_wdog_cnt (
    .clk_in, .rst_in, .en_i(stall_cyc), .clr_i(ifc.rdy_in && !p2), .q_o(run_cnt)
  );
  // Set on the edge that completes the WDOG_LIMIT-th consecutive stall.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) wdog_q <= 1'b0;
    else wdog_q <= wdog_q | (stall_cyc && run_cnt >= WW'(WDOG_LIMIT - 1));
  assign ifc.wdog_o = wdog_q;
`else
  assign ifc.wdog_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven bench with a scoreboard for the registered outputs.
module tb_pipe_hazard_ctrl;
  typedef struct {
    logic       rdy;
    logic [7:0] req;
    logic [7:0] ctl;
    logic       fl;
    logic [1:0] fs;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;
  typedef struct {
    logic       fl;
    logic [1:0] fs;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       wd;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  vec_t tab[18];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(4), .CNT_W(4)) ia ();
  pipe_hazard_ctrl_if #(.NSTAGE(6), .CNT_W(8)) ib ();

  pipe_hazard_ctrl #(.NSTAGE(4), .REDIRECT_LAT(2), .CNT_W(4), .WDOG_LIMIT(8)) dut_a (
    .clk_in(clk), .rst_in(rst), .ifc(ia)
  );
  pipe_hazard_ctrl #(.NSTAGE(6), .REDIRECT_LAT(0), .CNT_W(8), .WDOG_LIMIT(8)) dut_b (
    .clk_in(clk), .rst_in(rst), .ifc(ib)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sbq.pop_front();
      chk({e.name, " flush_o"}, 32'(ia.flush_o), 32'(e.fl));
      chk({e.name, " flush_stage_o"}, 32'(ia.flush_stage_o), 32'(e.fs));
      chk({e.name, " stall_cnt_o"}, 32'(ia.stall_cnt_o), 32'(e.sc));
      chk({e.name, " flush_cnt_o"}, 32'(ia.flush_cnt_o), 32'(e.fc));
      chk({e.name, " wdog_o"}, 32'(ia.wdog_o), 32'(e.wd));
    end
  endtask

  task automatic apply_a(input vec_t v, input logic wd, input string nm);
    @(negedge clk);
    ia.rdy_in = v.rdy;
    ia.req_i = v.req;
    #1 chk({nm, " ctl_o"}, 32'(ia.ctl_o), 32'(v.ctl));
    sbq.push_back('{v.fl, v.fs, v.sc, v.fc, wd, nm});
    @(posedge clk);
    #1 pop_cmp();
  endtask

  task automatic b_step(input logic [11:0] req, input logic [11:0] ctl, input logic fl,
                        input logic [2:0] fs, input logic [7:0] sc, input logic [7:0] fc,
                        input string nm);
    @(negedge clk);
    ib.req_i = req;
    #1 chk({nm, " ctl_o"}, 32'(ib.ctl_o), 32'(ctl));
    @(posedge clk);
    #1;
    chk({nm, " flush_o"}, 32'(ib.flush_o), 32'(fl));
    chk({nm, " flush_stage_o"}, 32'(ib.flush_stage_o), 32'(fs));
    chk({nm, " stall_cnt_o"}, 32'(ib.stall_cnt_o), 32'(sc));
    chk({nm, " flush_cnt_o"}, 32'(ib.flush_cnt_o), 32'(fc));
  endtask

  initial begin
    vec_t v;
    logic wd_e;
    tab[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 2'd0, 4'd0, 4'd0};
    tab[1]  = '{1'b1, 8'h10, 8'h95, 1'b0, 2'd0, 4'd1, 4'd0};
    tab[2]  = '{1'b1, 8'h24, 8'h20, 1'b1, 2'd2, 4'd1, 4'd1};
    tab[3]  = '{1'b1, 8'h00, 8'h08, 1'b0, 2'd2, 4'd1, 4'd1};
    tab[4]  = '{1'b1, 8'h40, 8'h55, 1'b0, 2'd2, 4'd2, 4'd1};
    tab[5]  = '{1'b0, 8'h40, 8'h55, 1'b0, 2'd2, 4'd2, 4'd1};
    tab[6]  = '{1'b0, 8'h40, 8'h55, 1'b0, 2'd2, 4'd2, 4'd1};
    tab[7]  = '{1'b0, 8'h40, 8'h55, 1'b0, 2'd2, 4'd2, 4'd1};
    tab[8]  = '{1'b1, 8'h40, 8'h55, 1'b0, 2'd2, 4'd3, 4'd1};
    tab[9]  = '{1'b1, 8'h00, 8'h08, 1'b0, 2'd2, 4'd3, 4'd1};
    tab[10] = '{1'b1, 8'h00, 8'h00, 1'b0, 2'd2, 4'd3, 4'd1};
    tab[11] = '{1'b1, 8'h88, 8'hA0, 1'b1, 2'd3, 4'd3, 4'd2};
    tab[12] = '{1'b1, 8'h20, 8'h28, 1'b1, 2'd2, 4'd3, 4'd3};
    tab[13] = '{1'b1, 8'h00, 8'h08, 1'b0, 2'd2, 4'd3, 4'd3};
    tab[14] = '{1'b1, 8'h00, 8'h08, 1'b0, 2'd2, 4'd3, 4'd3};
    tab[15] = '{1'b1, 8'h00, 8'h00, 1'b0, 2'd2, 4'd3, 4'd3};
    tab[16] = '{1'b1, 8'hC1, 8'h00, 1'b0, 2'd2, 4'd3, 4'd3};
    tab[17] = '{1'b1, 8'h04, 8'h25, 1'b0, 2'd2, 4'd4, 4'd3};
    ia.rdy_in = 1'b1;
    ia.req_i = '0;
    ib.rdy_in = 1'b1;
    ib.req_i = '0;
    #12;
    chk("reset ctl_o", 32'(ia.ctl_o), 32'h55);
    chk("reset flush_o", 32'(ia.flush_o), 32'd0);
    chk("reset flush_stage_o", 32'(ia.flush_stage_o), 32'd0);
    chk("reset stall_cnt_o", 32'(ia.stall_cnt_o), 32'd0);
    chk("reset flush_cnt_o", 32'(ia.flush_cnt_o), 32'd0);
    chk("reset wdog_o", 32'(ia.wdog_o), 32'd0);
    chk("reset ctl_o b", 32'(ib.ctl_o), 32'h555);
    @(negedge clk);
    rst = 1'b0;
    b_step(12'b01_00_10_00_00_00, 12'h555, 1'b0, 3'd0, 8'd1, 8'd0, "b stall5 over flush3");
    b_step(12'b00_00_10_00_00_00, 12'b00_00_10_10_00_00, 1'b1, 3'd3, 8'd1, 8'd1, "b flush3");
    b_step(12'b10_01_00_00_00_00, 12'b10_10_10_10_00_00, 1'b1, 3'd5, 8'd1, 8'd2, "b flush5 over stall4");
    b_step(12'b00_00_00_00_00_00, 12'h000, 1'b0, 3'd5, 8'd1, 8'd2, "b idle no drain");
    b_step(12'b00_01_00_00_00_00, 12'b10_01_01_01_01_01, 1'b0, 3'd5, 8'd2, 8'd2, "b stall4");
    for (int i = 0; i < 18; i++) apply_a(tab[i], 1'b0, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
`ifdef PIPE_HAZARD_WDOG_EN
      wd_e = i >= 6;
`else
      wd_e = 1'b0;
`endif
      v = '{1'b1, 8'h10, 8'h95, 1'b0, 2'd2, (5 + i > 15) ? 4'd15 : 4'(5 + i), 4'd3};
      apply_a(v, wd_e, $sformatf("sat%0d", i));
    end
    v = '{1'b1, 8'h20, 8'h20, 1'b1, 2'd2, 4'd15, 4'd4};
    apply_a(v, wd_e, "flush before reset");
    @(negedge clk);
    ia.req_i = '0;
    #2 rst = 1'b1;
    #1;
    chk("mid-drain reset ctl_o", 32'(ia.ctl_o), 32'h55);
    chk("mid-drain reset flush_o", 32'(ia.flush_o), 32'd0);
    chk("mid-drain reset flush_stage_o", 32'(ia.flush_stage_o), 32'd0);
    chk("mid-drain reset stall_cnt_o", 32'(ia.stall_cnt_o), 32'd0);
    chk("mid-drain reset flush_cnt_o", 32'(ia.flush_cnt_o), 32'd0);
    chk("mid-drain reset wdog_o", 32'(ia.wdog_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post-reset ctl_o no drain", 32'(ia.ctl_o), 32'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
